ifu_fetch: RTL and testbench

Instruction fetch unit: generates the fetch PC and drives the instruction-memory request/response interface. Buffers up to two returned instructions and presents them, with their PCs, to the IF/ID pipeline register. Honours the load-hazard stall and the branch/jump flush redirect from the execute stage, discarding stale in-flight responses after a redirect.

---
 rtl/ifu_fetch_if.sv | 26 ++
 rtl/ifu_fetch.sv | 123 ++++++++++++
 tb/tb_ifu_fetch.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - instruction-memory request/response bus between ifu_fetch and imem
interface ifu_fetch_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit with 2-entry buffer and flush-drop accounting
// Optional: IFU_MISALIGN_CHK_EN traps misaligned redirects on fetch_misalign.
module ifu_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] redirect_pc,
  ifu_fetch_if.master     imem,
  output logic            valid_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] instruction_out,
  output logic            fetch_misalign
);

  logic [XLEN-1:0] fetch_pc;

  logic [XLEN-1:0] fifo_pc    [2];
  logic [XLEN-1:0] fifo_instr [2];
  logic            fifo_rd;
  logic [1:0]      fifo_cnt;
  logic            fifo_wr;

  logic [XLEN-1:0] pend_pc [2];
  logic            pend_wr;
  logic            pend_rd;

  logic [1:0]      outstanding;
  logic [1:0]      drop_cnt;
  logic            misalign_q;

  logic            resp;
  logic            keep;
  logic            pop;
  logic            fire;
  logic [2:0]      in_use;
  logic [XLEN-1:0] redirect_tgt;

  // Responses without a matching request are protocol violations and ignored.
  assign resp = imem.imem_rvalid & (outstanding != 2'd0);
  assign keep = resp & (drop_cnt == 2'd0) & !flush;

  assign valid_out = (fifo_cnt != 2'd0) & !flush;
  assign pop       = valid_out & !stall;

  // Slot being popped this cycle is credited back so L=1 fetch sustains one per cycle.
  assign in_use = {1'b0, fifo_cnt} + {1'b0, outstanding} - {2'b00, pop};

  assign imem.imem_req  = !rst & !flush & !misalign_q & (in_use < 3'd2);
  assign imem.imem_addr = fetch_pc;
  assign fire           = imem.imem_req & imem.imem_ready;

  assign fifo_wr = fifo_rd ^ fifo_cnt[0];

  assign pc_out          = valid_out ? fifo_pc[fifo_rd]    : '0;
  assign instruction_out = valid_out ? fifo_instr[fifo_rd] : '0;
  assign fetch_misalign  = misalign_q;

`ifdef IFU_MISALIGN_CHK_EN
  assign redirect_tgt = redirect_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (flush) begin
      misalign_q <= (redirect_pc[1:0] != 2'b00);
    end
  end
`else
  assign redirect_tgt = redirect_pc & ~XLEN'(3);
  assign misalign_q   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      fifo_cnt    <= 2'd0;
      fifo_rd     <= 1'b0;
      outstanding <= 2'd0;
      drop_cnt    <= 2'd0;
      pend_wr     <= 1'b0;
      pend_rd     <= 1'b0;
    end else begin
      if (resp) begin
        pend_rd <= ~pend_rd;
      end
      if (flush) begin
        // Everything still in flight after this cycle belongs to the old path.
        fetch_pc    <= redirect_tgt;
        fifo_cnt    <= 2'd0;
        outstanding <= outstanding - {1'b0, resp};
        drop_cnt    <= outstanding - {1'b0, resp};
      end else begin
        if (fire) begin
          fetch_pc <= fetch_pc + XLEN'(4);
          pend_wr  <= ~pend_wr;
        end
        outstanding <= outstanding + {1'b0, fire} - {1'b0, resp};
        if (resp && (drop_cnt != 2'd0)) begin
          drop_cnt <= drop_cnt - 2'd1;
        end
        if (pop) begin
          fifo_rd <= ~fifo_rd;
        end
        fifo_cnt <= fifo_cnt + {1'b0, keep} - {1'b0, pop};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fire) begin
      pend_pc[pend_wr] <= fetch_pc;
    end
    if (keep) begin
      fifo_pc[fifo_wr]    <= pend_pc[pend_rd];
      fifo_instr[fifo_wr] <= imem.imem_rdata;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed self-checking bench for ifu_fetch
module tb_ifu_fetch;
  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        fetch_misalign;

  ifu_fetch_if #(.XLEN(XLEN)) imem_bus ();

  ifu_fetch #(.XLEN(XLEN), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .redirect_pc     (redirect_pc),
    .imem            (imem_bus),
    .valid_out       (valid_out),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .fetch_misalign  (fetch_misalign)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model: fixed latency, in order; data 0x13 or ~addr.
  int          lat = 1;
  bit          fixed_data = 1'b1;
  int          cyc = 0;
  logic [31:0] q_addr [$];
  int          q_due  [$];

  initial imem_bus.imem_ready = 1'b1;

  always @(posedge clk) begin
    if (rst) begin
      q_addr.delete();
      q_due.delete();
    end else if (imem_bus.imem_req && imem_bus.imem_ready) begin
      q_addr.push_back(imem_bus.imem_addr);
      q_due.push_back(cyc + lat);
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (q_addr.size() != 0 && q_due[0] <= cyc) begin
      imem_bus.imem_rvalid = 1'b1;
      imem_bus.imem_rdata  = fixed_data ? 32'h0000_0013 : ~q_addr[0];
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end else begin
      imem_bus.imem_rvalid = 1'b0;
      imem_bus.imem_rdata  = 32'h0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int l, input bit fx);
    rst = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    redirect_pc = 32'h0;
    lat = l;
    fixed_data = fx;
    step();
    step();
    look();
    check_eq("rst_req", imem_bus.imem_req, 32'd0);
    check_eq("rst_valid", valid_out, 32'd0);
    check_eq("rst_pc", pc_out, 32'd0);
    check_eq("rst_instr", instruction_out, 32'd0);
    check_eq("rst_misalign", fetch_misalign, 32'd0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Streaming fetch, L=1
    do_reset(1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      look();
      check_eq("t1_req", imem_bus.imem_req, 32'd1);
      check_eq("t1_addr", imem_bus.imem_addr, 32'(4 * k));
      if (k >= 2) begin
        check_eq("t1_valid", valid_out, 32'd1);
        check_eq("t1_pc", pc_out, 32'(4 * (k - 2)));
        check_eq("t1_instr", instruction_out, 32'h0000_0013);
      end else begin
        check_eq("t1_valid0", valid_out, 32'd0);
      end
      step();
    end

    // Stall 5 cycles with FIFO filling to 2
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      look();
      check_eq("t2_stall_req", imem_bus.imem_req, 32'd0);
      check_eq("t2_stall_valid", valid_out, 32'd1);
      check_eq("t2_stall_pc", pc_out, 32'd24);
      check_eq("t2_stall_instr", instruction_out, 32'h0000_0013);
      step();
    end
    stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      look();
      check_eq("t2_rel_valid", valid_out, 32'd1);
      check_eq("t2_rel_pc", pc_out, 32'(24 + 4 * k));
      check_eq("t2_rel_req", imem_bus.imem_req, 32'd1);
      check_eq("t2_rel_addr", imem_bus.imem_addr, 32'(32 + 4 * k));
      step();
    end

    // Flush with two outstanding, L=3
    do_reset(3, 1'b0);
    look(); check_eq("t3_addr0", imem_bus.imem_addr, 32'h0); check_eq("t3_req0", imem_bus.imem_req, 32'd1); step();
    look(); check_eq("t3_addr1", imem_bus.imem_addr, 32'h4); check_eq("t3_req1", imem_bus.imem_req, 32'd1); step();
    flush = 1'b1; redirect_pc = 32'h100;
    look(); check_eq("t3_fl_req", imem_bus.imem_req, 32'd0); check_eq("t3_fl_valid", valid_out, 32'd0); step();
    flush = 1'b0;
    look(); check_eq("t3_c3_req", imem_bus.imem_req, 32'd0); check_eq("t3_c3_valid", valid_out, 32'd0); step();
    look(); check_eq("t3_c4_req", imem_bus.imem_req, 32'd1); check_eq("t3_c4_addr", imem_bus.imem_addr, 32'h100);
    check_eq("t3_c4_valid", valid_out, 32'd0); step();
    look(); check_eq("t3_c5_addr", imem_bus.imem_addr, 32'h104); check_eq("t3_c5_valid", valid_out, 32'd0); step();
    look(); check_eq("t3_c6_req", imem_bus.imem_req, 32'd0); check_eq("t3_c6_valid", valid_out, 32'd0); step();
    look(); check_eq("t3_c7_req", imem_bus.imem_req, 32'd0); check_eq("t3_c7_valid", valid_out, 32'd0); step();
    look(); check_eq("t3_c8_valid", valid_out, 32'd1); check_eq("t3_c8_pc", pc_out, 32'h100);
    check_eq("t3_c8_instr", instruction_out, 32'hFFFF_FEFF); check_eq("t3_c8_addr", imem_bus.imem_addr, 32'h108); step();
    look(); check_eq("t3_c9_pc", pc_out, 32'h104); check_eq("t3_c9_instr", instruction_out, 32'hFFFF_FEFB); step();

    // Flush + stall + response in the same cycle
    do_reset(1, 1'b0);
    step();
    step();
    stall = 1'b1; flush = 1'b1; redirect_pc = 32'h40;
    look(); check_eq("t4_valid", valid_out, 32'd0); check_eq("t4_pc", pc_out, 32'd0);
    check_eq("t4_instr", instruction_out, 32'd0); check_eq("t4_req", imem_bus.imem_req, 32'd0); step();
    stall = 1'b0; flush = 1'b0;
    look(); check_eq("t4_c3_req", imem_bus.imem_req, 32'd1); check_eq("t4_c3_addr", imem_bus.imem_addr, 32'h40);
    check_eq("t4_c3_valid", valid_out, 32'd0); step();
    look(); check_eq("t4_c4_valid", valid_out, 32'd0); check_eq("t4_c4_addr", imem_bus.imem_addr, 32'h44); step();
    look(); check_eq("t4_c5_valid", valid_out, 32'd1); check_eq("t4_c5_pc", pc_out, 32'h40);
    check_eq("t4_c5_instr", instruction_out, 32'hFFFF_FFBF); step();

    // Address wrap at 0xFFFFFFFC
    do_reset(1, 1'b0);
    flush = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    look(); check_eq("t5_fl_req", imem_bus.imem_req, 32'd0); step();
    flush = 1'b0;
    look(); check_eq("t5_addr_top", imem_bus.imem_addr, 32'hFFFF_FFFC); check_eq("t5_req_top", imem_bus.imem_req, 32'd1); step();
    look(); check_eq("t5_addr_wrap", imem_bus.imem_addr, 32'h0); step();
    look(); check_eq("t5_pc_top", pc_out, 32'hFFFF_FFFC); check_eq("t5_instr_top", instruction_out, 32'h0000_0003); step();
    look(); check_eq("t5_pc_wrap", pc_out, 32'h0); check_eq("t5_instr_wrap", instruction_out, 32'hFFFF_FFFF); step();

    // Misaligned redirect
    do_reset(1, 1'b0);
    flush = 1'b1; redirect_pc = 32'h102;
    look(); check_eq("t6_fl_req", imem_bus.imem_req, 32'd0); step();
    flush = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
    look(); check_eq("t6_mis_set", fetch_misalign, 32'd1); check_eq("t6_mis_req", imem_bus.imem_req, 32'd0); step();
    look(); check_eq("t6_mis_hold", fetch_misalign, 32'd1); check_eq("t6_mis_req2", imem_bus.imem_req, 32'd0);
    check_eq("t6_mis_valid", valid_out, 32'd0); step();
    flush = 1'b1; redirect_pc = 32'h200;
    look(); step();
    flush = 1'b0;
    look(); check_eq("t6_mis_clr", fetch_misalign, 32'd0); check_eq("t6_clr_req", imem_bus.imem_req, 32'd1);
    check_eq("t6_clr_addr", imem_bus.imem_addr, 32'h200); step();
`else
    look(); check_eq("t6_mis_zero", fetch_misalign, 32'd0); check_eq("t6_req", imem_bus.imem_req, 32'd1);
    check_eq("t6_addr", imem_bus.imem_addr, 32'h100); step();
    look(); check_eq("t6_addr2", imem_bus.imem_addr, 32'h104); step();
    look(); check_eq("t6_pc", pc_out, 32'h100); check_eq("t6_instr", instruction_out, 32'hFFFF_FEFF); step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
